uart_rx_core: RTL and testbench

- Receive half of the UART link.
- Recovers asynchronous serial frames from rx_in using a prescale-oversampled bit clock, and deserializes data LSB first.
- Checks optional parity and the stop bit, then presents p_data with a one-cycle data_valid strobe to the downstream register/system-control block.
- Frame format: 1 start bit, DATA_WIDTH data bits, optional parity bit, 1 stop bit.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_sampler.sv | 38 +++
 rtl/uart_rx_core.sv | 141 ++++++++++++++
 tb/tb_uart_rx_core.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, parity sense and
// the supported oversampling ratios.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  // Unsupported ratios fall back to the slowest legal oversampling.
  function automatic int unsigned norm_prescale(input int unsigned p);
    if (p == PRESCALE_16 || p == PRESCALE_32) return p;
    return PRESCALE_8;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Mid-bit 3-sample capture with 2-of-3 majority vote; the vote is stable from
// edge P/2+2 to the end of the bit.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_in,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_val
);

  localparam int PW = PRESCALE_WIDTH;

  logic [PW-1:0] half;
  logic [2:0]    samp_q, samp_d;

  assign half = prescale >> 1;

  always_comb begin
    samp_d = samp_q;
    if (edge_cnt == half - PW'(1)) samp_d[0] = rx_in;
    if (edge_cnt == half)          samp_d[1] = rx_in;
    if (edge_cnt == half + PW'(1)) samp_d[2] = rx_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) samp_q <= '0;
    else        samp_q <= samp_d;
  end

  assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                   (samp_q[1] & samp_q[2]);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: start/data/parity/stop FSM with oversampled bit timing,
// LSB-first deserializer and one-cycle end-of-frame status strobes.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      par_en,
  input  logic                      par_typ,
  output logic [DATA_WIDTH-1:0]     p_data,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err
);

  localparam int PW = PRESCALE_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int BW = $clog2(DATA_WIDTH) + 1;

  rx_state_e     state_q, state_d;
  logic [PW-1:0] edge_cnt_q, edge_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [DW-1:0] p_data_q, p_data_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          par_en_q, par_en_d;
  logic          par_typ_q, par_typ_d;
  logic          par_flag_q, par_flag_d;
  logic          dv_q, dv_d, pe_q, pe_d, se_q, se_d;
  logic          bit_val, bit_end, stop_bad;

  uart_rx_sampler #(.PRESCALE_WIDTH(PW)) u_sampler (
    .clk      (clk),
    .reset    (reset),
    .rx_in    (rx_in),
    .edge_cnt (edge_cnt_q),
    .prescale (presc_q),
    .bit_val  (bit_val)
  );

  assign bit_end  = (edge_cnt_q == presc_q - PW'(1));
  assign stop_bad = !bit_val;

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = bit_end ? '0 : edge_cnt_q + PW'(1);
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    p_data_d   = p_data_q;
    presc_d    = presc_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_flag_d = par_flag_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        // Detect cycle is edge 0 of the start bit; config is frozen here.
        if (!rx_in) begin
          state_d    = START;
          edge_cnt_d = PW'(1);
          presc_d    = PW'(norm_prescale(32'(prescale)));
          par_en_d   = par_en;
          par_typ_d  = par_typ;
        end
      end
      START: begin
        if (bit_end) state_d = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = {bit_val, shift_q[DW-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(DW - 1)) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) begin
          if (bit_val != ((^shift_q) ^ (par_typ_q == PAR_ODD))) par_flag_d = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        // Strobes are registered so they appear in the first IDLE cycle.
        if (bit_end) begin
          dv_d       = !par_flag_q && !stop_bad;
          pe_d       = par_flag_q;
          se_d       = stop_bad;
          par_flag_d = 1'b0;
          if (dv_d) p_data_d = shift_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      p_data_q   <= '0;
      presc_q    <= PW'(PRESCALE_8);
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      par_flag_q <= 1'b0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      p_data_q   <= p_data_d;
      presc_q    <= presc_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_flag_q <= par_flag_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

  assign p_data     = p_data_q;
  assign data_valid = dv_q;
  assign par_err    = pe_q;
  assign stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboarded bench for uart_rx_core: frame-level reference model pushes the
// expected strobe (cycle, flags, p_data); a monitor checks every strobe.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en, par_typ;
  logic [7:0] p_data;
  logic       data_valid, par_err, stp_err;

  uart_rx_core #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int unsigned when;
    bit          dv, pe, se;
    logic [7:0]  pd;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_pdata = 8'h00;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && (data_valid || par_err || stp_err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {data_valid, par_err, stp_err}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("strobe_cycle", int'(cyc), int'(e.when));
        chk("data_valid", int'(data_valid), int'(e.dv));
        chk("par_err", int'(par_err), int'(e.pe));
        chk("stp_err", int'(stp_err), int'(e.se));
        chk("p_data", int'(p_data), int'(e.pd));
      end
    end
  end

  function automatic int eff_p(input int p);
    return (p == 16 || p == 32) ? p : 8;
  endfunction

  task automatic hold_bit(input bit v, input int p, input bit scramble);
    rx_in = v;
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      // Config must be ignored once the frame has started.
      if (scramble && i == 0) begin
        prescale = 6'($urandom);
        par_en   = 1'($urandom);
        par_typ  = 1'($urandom);
      end
    end
  endtask

  // Called at a negedge; returns at the negedge where the next bit would begin.
  task automatic send_frame(input logic [7:0] d, input int pres_in, input bit pen,
                            input bit ptyp, input bit bad_par, input bit stop_v);
    int          p, nbits;
    bit          pbit, pflag, sflag;
    exp_t        e;
    int unsigned t0;
    p     = eff_p(pres_in);
    nbits = pen ? 11 : 10;
    pbit  = ((($countones(d) % 2) == 1) ^ ptyp) ^ bad_par;
    pflag = pen && ((($countones(d) + int'(pbit)) % 2) != (ptyp ? 1 : 0));
    sflag = !stop_v;
    prescale = 6'(pres_in);
    par_en   = pen;
    par_typ  = ptyp;
    t0 = cyc;
    e.when = t0 + nbits * p;
    e.dv   = !pflag && !sflag;
    e.pe   = pflag;
    e.se   = sflag;
    if (e.dv) model_pdata = d;
    e.pd = model_pdata;
    sb.push_back(e);
    hold_bit(1'b0, p, 1'b1);
    for (int b = 0; b < 8; b++) hold_bit(d[b], p, 1'b0);
    if (pen) hold_bit(pbit, p, 1'b0);
    hold_bit(stop_v, p, 1'b0);
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_p_data", int'(p_data), 0);
    chk("reset_strobes", int'({data_valid, par_err, stp_err}), 0);
    reset = 1'b1;
    idle(4);

    send_frame(8'hA5, 8, 0, 0, 0, 1);            idle(5);
    send_frame(8'h3C, 16, 1, 0, 0, 1);           idle(3);
    send_frame(8'h3C, 16, 1, 0, 1, 1);           idle(3);
    send_frame(8'h01, 16, 1, 1, 0, 1);           idle(3);
    send_frame(8'h5A, 32, 0, 0, 0, 0);           idle(6);

    // Short low pulse on the line must be rejected as a false start.
    prescale = 6'd8; par_en = 1'b0;
    rx_in = 1'b0; repeat (3) @(negedge clk);
    idle(20);
    send_frame(8'h0F, 8, 0, 0, 0, 1);            idle(4);

    // Abort mid-frame during data bit 4.
    prescale = 6'd8; par_en = 1'b0;
    hold_bit(1'b0, 8, 1'b0);
    for (int b = 0; b < 4; b++) hold_bit(b[0], 8, 1'b0);
    rx_in = 1'b0; repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_p_data", int'(p_data), 0);
    chk("abort_strobes", int'({data_valid, par_err, stp_err}), 0);
    model_pdata = 8'h00;
    idle(3);
    reset = 1'b1;
    idle(2);
    send_frame(8'h55, 8, 0, 0, 0, 1);
    send_frame(8'hAA, 8, 0, 0, 0, 1);            idle(4);

    // Randomized frames, including unsupported prescale codes and errors.
    for (int n = 0; n < 24; n++) begin
      int          pc;
      int unsigned r;
      r  = $urandom_range(0, 4);
      pc = (r == 0) ? 8 : (r == 1) ? 16 : (r == 2) ? 32 : (r == 3) ? 12 : 5;
      send_frame(8'($urandom), pc, 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0));
      idle($urandom_range(0, 3));
    end

    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
    chk("pending_expectations", sb.size(), 0);
    idle(50);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
